// File: rtl/ask_pkg.sv
// Shared constants and types for the 4-level ASK demodulator.
package ask_pkg;

  // Samples per symbol; one full carrier period.
  localparam int DEF_SYM_LEN = 25;

  // Magnitude-sum width. The largest possible sum is 25*2048 = 51200.
  localparam int ACC_W = 16;

  // Sample width at the modulator interface.
  localparam int SAMPLE_W = 12;

  // Default decision thresholds: midpoints between the nominal sums of a
  // 2047-peak, 25-point sine at the four modulation depths.
  localparam int DEF_TH1 = 5336;
  localparam int DEF_TH2 = 16012;
  localparam int DEF_TH3 = 26940;

  // Decided 2-bit symbol.
  typedef logic [1:0] sym_t;

  // Demodulator FSM state encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Two's-complement magnitude. -2048 maps to 2048 because the 12-bit
  // result is read as unsigned, so there is no need to saturate.
  function automatic logic [SAMPLE_W-1:0] mag12(input logic signed [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] ux;
    ux = $unsigned(x);
    return x[SAMPLE_W-1] ? (~ux + 12'd1) : ux;
  endfunction

endpackage

// File: rtl/ask_slicer.sv
// Three-threshold slicer: maps a magnitude sum onto a 2-bit symbol.
// A sum equal to a threshold is given the higher symbol.
module ask_slicer
  import ask_pkg::*;
#(
  parameter logic [ACC_W-1:0] TH1 = ACC_W'(DEF_TH1),
  parameter logic [ACC_W-1:0] TH2 = ACC_W'(DEF_TH2),
  parameter logic [ACC_W-1:0] TH3 = ACC_W'(DEF_TH3)
) (
  input  logic [ACC_W-1:0] total_i,
  output sym_t             sym_o
);

  // Compare against the thresholds from the top down.
  always_comb begin
    sym_o = 2'd0;
    if (total_i >= TH3) begin
      sym_o = 2'd3;
    end else if (total_i >= TH2) begin
      sym_o = 2'd2;
    end else if (total_i >= TH1) begin
      sym_o = 2'd1;
    end
  end

endmodule

// File: rtl/ask_demod.sv
// Non-coherent 4-level ASK demodulator: integrates |x| over each
// SYM_LEN-sample symbol and slices the total at symbol end.
module ask_demod
  import ask_pkg::*;
#(
  parameter int SYM_LEN = DEF_SYM_LEN,
  parameter int TH1     = DEF_TH1,
  parameter int TH2     = DEF_TH2,
  parameter int TH3     = DEF_TH3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       ask_valid_i,
  input  logic signed [SAMPLE_W-1:0] ask_din,
  output sym_t                       sym_dout,
  output logic [ACC_W-1:0]           sym_lvl_o,
  output logic                       sym_valid_o
);

  localparam int CNT_W = $clog2(SYM_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  sym_t                sym_q, sym_d;
  logic [ACC_W-1:0]    lvl_q, lvl_d;
  logic                valid_q, valid_d;

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    total;
  sym_t                slice_sym;

  // Magnitude of the current sample and running total including it.
  always_comb begin
    mag   = mag12(ask_din);
    total = acc_q + ACC_W'(mag);
  end

  ask_slicer #(
    .TH1 (ACC_W'(TH1)),
    .TH2 (ACC_W'(TH2)),
    .TH3 (ACC_W'(TH3))
  ) u_slicer (
    .total_i (total),
    .sym_o   (slice_sym)
  );

  // Next-state logic: start, accumulate, decide at the last sample, or
  // abort the partial symbol when valid drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sym_d   = sym_q;
    lvl_d   = lvl_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        acc_d = '0;
        if (ask_valid_i) begin
          acc_d   = ACC_W'(mag);
          cnt_d   = CNT_W'(1);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (!ask_valid_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          sym_d   = slice_sym;
          lvl_d   = total;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = total;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, accumulator and output registers; reset discards any
  // partial symbol.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sym_q   <= '0;
      lvl_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sym_q   <= sym_d;
      lvl_q   <= lvl_d;
      valid_q <= valid_d;
    end
  end

  assign sym_dout    = sym_q;
  assign sym_lvl_o   = lvl_q;
  assign sym_valid_o = valid_q;

endmodule

// File: tb/tb_ask_demod.sv
// Directed bench for ask_demod: table of symbols sent back-to-back, then
// abort and reset sequences.
module tb_ask_demod;

  logic               clk;
  logic               rstn;
  logic               ask_valid_i;
  logic signed [11:0] ask_din;
  logic [1:0]         sym_dout;
  logic [15:0]        sym_lvl_o;
  logic               sym_valid_o;

  ask_demod dut (
    .clk         (clk),
    .rstn        (rstn),
    .ask_valid_i (ask_valid_i),
    .ask_din     (ask_din),
    .sym_dout    (sym_dout),
    .sym_lvl_o   (sym_lvl_o),
    .sym_valid_o (sym_valid_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // mode 0: sine, a = depth*10000; mode 1: 24 x a then b; mode 2: +a,-a,...
  typedef struct {
    int mode;
    int a;
    int b;
    int exp_sym;
    int exp_lvl;
    int tol;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl[NV];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int q_sym[$];
  int q_lvl[$];
  int q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with its cycle stamp.
  always @(negedge clk) begin
    if (sym_valid_o === 1'b1) begin
      q_sym.push_back(int'(sym_dout));
      q_lvl.push_back(int'(sym_lvl_o));
      q_cyc.push_back(cyc);
      $display("strobe: cyc=%0d sym=%0d lvl=%0d", cyc, sym_dout, sym_lvl_o);
    end
  end

  function automatic int samp(vec_t v, int k);
    real s;
    case (v.mode)
      0: begin
        s = 2047.0 * real'(v.a) / 10000.0 * $sin(6.283185307179586 * real'(k) / 25.0);
        return int'(s);
      end
      1: return (k == 24) ? v.b : v.a;
      default: return (k % 2 == 0) ? v.a : -v.a;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end else begin
      $display("ok   %s: %0d (nominal %0d)", name, act, exp);
    end
  endtask

  task automatic drive_sym(input vec_t v, input int n, output int c0);
    c0 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      ask_valid_i = 1'b1;
      ask_din     = 12'(samp(v, k));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ask_valid_i = 1'b0;
      ask_din     = '0;
    end
  endtask

  task automatic clear_q();
    q_sym.delete();
    q_lvl.delete();
    q_cyc.delete();
  endtask

  initial begin
    int c0;
    int ctmp;
    int n;

    //          mode  a      b     sym lvl    tol
    tbl[0]  = '{0, 10000, 0,    3, 32530, 64};  // modulator level 3
    tbl[1]  = '{0, 6563,  0,    2, 21350, 64};  // level 2
    tbl[2]  = '{0, 3281,  0,    1, 10673, 64};  // level 1
    tbl[3]  = '{0, 0,     0,    0, 0,     64};  // level 0
    tbl[4]  = '{1, -2048, -2048, 3, 51200, 0};  // |min| with no wrap
    tbl[5]  = '{2, -1000, 0,    2, 25000, 0};   // alternating sign
    tbl[6]  = '{1, 213,   223,  0, 5335,  0};   // TH1 - 1
    tbl[7]  = '{1, 213,   224,  1, 5336,  0};   // TH1
    tbl[8]  = '{1, 600,   1611, 1, 16011, 0};   // TH2 - 1
    tbl[9]  = '{1, 600,   1612, 2, 16012, 0};   // TH2
    tbl[10] = '{1, 1050,  1739, 2, 26939, 0};   // TH3 - 1
    tbl[11] = '{1, 1050,  1740, 3, 26940, 0};   // TH3

    rstn        = 1'b0;
    ask_valid_i = 1'b0;
    ask_din     = '0;
    repeat (3) @(negedge clk);
    chk("reset_sym", int'(sym_dout), 0);
    chk("reset_lvl", int'(sym_lvl_o), 0);
    chk("reset_valid", int'(sym_valid_o), 0);
    rstn = 1'b1;
    idle(2);

    // Whole table back-to-back with valid held high.
    clear_q();
    c0 = 0;
    for (int r = 0; r < NV; r++) begin
      drive_sym(tbl[r], 25, ctmp);
      if (r == 0) c0 = ctmp;
    end
    idle(3);
    chk("table_strobes", q_sym.size(), NV);
    n = (q_sym.size() < NV) ? q_sym.size() : NV;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("vec%0d_sym", i), q_sym[i], tbl[i].exp_sym);
      chk_tol($sformatf("vec%0d_lvl", i), q_lvl[i], tbl[i].exp_lvl, tbl[i].tol);
      chk($sformatf("vec%0d_cycle", i), q_cyc[i], c0 + 25 * (i + 1));
    end
    chk("hold_sym", int'(sym_dout), tbl[NV-1].exp_sym);
    chk("hold_lvl", int'(sym_lvl_o), tbl[NV-1].exp_lvl);

    // Abort after 10 samples, then a full level-2 symbol.
    clear_q();
    drive_sym(tbl[1], 10, ctmp);
    idle(3);
    drive_sym(tbl[1], 25, c0);
    idle(3);
    chk("abort10_strobes", q_sym.size(), 1);
    if (q_sym.size() > 0) begin
      chk("abort10_sym", q_sym[0], 2);
      chk("abort10_cycle", q_cyc[0], c0 + 25);
    end

    // Abort on the would-be 25th sample, then a clean level-1 symbol.
    clear_q();
    drive_sym(tbl[0], 24, ctmp);
    idle(3);
    chk("abort25_strobes", q_sym.size(), 0);
    drive_sym(tbl[2], 25, c0);
    idle(3);
    chk("after_abort25_strobes", q_sym.size(), 1);
    if (q_sym.size() > 0) begin
      chk("after_abort25_sym", q_sym[0], 1);
      chk("after_abort25_cycle", q_cyc[0], c0 + 25);
    end

    // Reset in the middle of a symbol (outputs currently hold symbol 1).
    clear_q();
    drive_sym(tbl[0], 12, ctmp);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_sym", int'(sym_dout), 0);
    chk("midrst_lvl", int'(sym_lvl_o), 0);
    chk("midrst_valid", int'(sym_valid_o), 0);
    ask_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drive_sym(tbl[0], 25, c0);
    idle(3);
    chk("postrst_strobes", q_sym.size(), 1);
    if (q_sym.size() > 0) begin
      chk("postrst_sym", q_sym[0], 3);
      chk_tol("postrst_lvl", q_lvl[0], 32530, 64);
      chk("postrst_cycle", q_cyc[0], c0 + 25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
